// File: rtl/fetch_pkg.sv
// Shared defaults, buffer entry type and address helper for the instruction fetch stage.
package fetch_pkg;

    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
    localparam int unsigned FETCH_DEPTH    = 2;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response bus and decode-side instruction handshake.
interface fetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output instr_valid, instr, instr_pc, opcode, funct3, funct7,
        input  instr_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  instr_valid, instr, instr_pc, opcode, funct3, funct7,
        output instr_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Instruction buffer: DEPTH-entry FIFO of {instr, pc} with flush that wins over push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = FETCH_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  fetch_entry_t           wdata,
    output fetch_entry_t           rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    fetch_entry_t  mem_r [DEPTH];
    logic [AW-1:0] wptr_r;
    logic [AW-1:0] rptr_r;
    logic [AW:0]   count_r;
    logic          push_s;
    logic          pop_s;

    // Qualify requests: a push into a full buffer is accepted only alongside a pop.
    always_comb begin
        pop_s  = pop & ~empty;
        push_s = push & (~full | pop_s);
    end

    // Pointer, occupancy and storage update; flush only rewinds pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= '0;
            end
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
        end else if (flush) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
        end else begin
            if (push_s) begin
                mem_r[wptr_r] <= wdata;
                wptr_r        <= wptr_r + AW'(1);
            end
            if (pop_s) begin
                rptr_r <= rptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign rdata = mem_r[rptr_r];
    assign empty = (count_r == '0);
    assign full  = (count_r == DEPTH_C);
    assign count = count_r;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: sequential PC, throttled memory requests, redirect flush with stale-response dropping.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
    parameter int unsigned DEPTH    = FETCH_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    fetch_if.master     bus
);

    localparam int unsigned CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    logic [31:0]   pc_r;
    logic [31:0]   pc_nxt_s;
    logic [CW-1:0] outstanding_r;
    logic [CW-1:0] outstanding_nxt_s;
    logic [CW-1:0] drop_r;
    logic [CW-1:0] drop_nxt_s;
    logic [CW-1:0] occupancy_s;
    logic [CW:0]   inflight_s;
    logic          grant_s;
    logic          resp_s;
    logic          keep_s;
    logic          pop_s;
    logic          empty_s;
    logic          full_s;
    fetch_entry_t  push_entry_s;
    fetch_entry_t  head_entry_s;

    // Request throttling and response steering. Kept responses always belong to the
    // contiguous run starting at the last redirect, so the oldest one sits outstanding words behind PC.
    always_comb begin
        inflight_s         = {1'b0, occupancy_s} + {1'b0, outstanding_r};
        bus.imem_req       = ~rst & ~redirect & ~full_s & (inflight_s < DEPTH_C);
        bus.imem_addr      = word_align(pc_r);
        grant_s            = bus.imem_req & bus.imem_gnt;
        resp_s             = bus.imem_rvalid & (outstanding_r != '0);
        keep_s             = resp_s & (drop_r == '0) & ~redirect;
        pop_s              = ~empty_s & bus.instr_ready & ~redirect;
        push_entry_s.instr = bus.imem_rdata;
        push_entry_s.pc    = pc_r - {{(30-CW){1'b0}}, outstanding_r, 2'b00};
    end

    // Next PC, outstanding and drop counts; a redirect drops whatever is still in flight after this cycle.
    always_comb begin
        outstanding_nxt_s = outstanding_r;
        pc_nxt_s          = pc_r;
        drop_nxt_s        = drop_r;
        if (grant_s & ~resp_s) begin
            outstanding_nxt_s = outstanding_r + CW'(1);
        end else if (~grant_s & resp_s) begin
            outstanding_nxt_s = outstanding_r - CW'(1);
        end else begin
            outstanding_nxt_s = outstanding_r;
        end
        if (redirect) begin
            pc_nxt_s   = word_align(redirect_pc);
            drop_nxt_s = outstanding_nxt_s;
        end else begin
            pc_nxt_s   = grant_s ? (pc_r + 32'd4) : pc_r;
            drop_nxt_s = (resp_s && (drop_r != '0)) ? (drop_r - CW'(1)) : drop_r;
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r          <= word_align(RESET_PC);
            outstanding_r <= '0;
            drop_r        <= '0;
        end else begin
            pc_r          <= pc_nxt_s;
            outstanding_r <= outstanding_nxt_s;
            drop_r        <= drop_nxt_s;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (keep_s),
        .pop   (pop_s),
        .flush (redirect),
        .wdata (push_entry_s),
        .rdata (head_entry_s),
        .full  (full_s),
        .empty (empty_s),
        .count (occupancy_s)
    );

    assign bus.instr_valid = ~empty_s;
    assign bus.instr       = head_entry_s.instr;
    assign bus.instr_pc    = head_entry_s.pc;
    assign bus.opcode      = head_entry_s.instr[6:0];
    assign bus.funct3      = head_entry_s.instr[14:12];
    assign bus.funct7      = head_entry_s.instr[30];

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: in-order memory model, scoreboard of expected instruction addresses,
// a table of redirect runs, and hand sequences for stalls, stale drops and reset.
module tb_fetch_stage;
    import fetch_pkg::*;

    typedef struct {
        logic [31:0] start;
        logic [31:0] first;
        int          n;
        bit          alt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    bit          hold;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q  [$];
    logic [31:0] pend_q [$];

    fetch_if bus ();

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .bus         (bus.master)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return (pc * 32'h9E37_79B9) ^ 32'h0000_5A13;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: sample handshakes at the falling edge, then advance the memory model after the rising edge.
    task automatic tick();
        logic        g;
        logic [31:0] a;
        logic [31:0] e;
        logic [31:0] w;
        @(negedge clk);
        g = bus.imem_req & bus.imem_gnt;
        a = bus.imem_addr;
        if (bus.instr_valid && bus.instr_ready && !redirect) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got pc %h expected no instruction", bus.instr_pc);
            end else begin
                e = exp_q.pop_front();
                w = word_of(e);
                check("instr_pc", bus.instr_pc, e);
                check("instr", bus.instr, w);
                check("decode", {21'd0, bus.funct7, bus.funct3, bus.opcode}, {21'd0, w[30], w[14:12], w[6:0]});
            end
        end
        @(posedge clk);
        #1;
        if (g) pend_q.push_back(a);
        if (!hold && pend_q.size() > 0) begin
            a = pend_q.pop_front();
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = word_of(a);
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = 32'h0000_0000;
        end
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        redirect        = 1'b0;
        redirect_pc     = 32'h0000_0000;
        hold            = 1'b0;
        bus.imem_gnt    = 1'b1;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0000_0000;
        bus.instr_ready = 1'b0;
        pend_q.delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", 32'(bus.imem_req), 32'd0);
        check("rst_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_instr", bus.instr, 32'h0000_0000);
        check("rst_instr_pc", bus.instr_pc, 32'h0000_0000);
        rst = 1'b0;
        #1;
    endtask

    // Consume until every expected instruction has been seen or the cycle budget runs out.
    task automatic drain(input int budget, input bit alternate, input string name);
        int n;
        n = 0;
        bus.instr_ready = 1'b1;
        while (exp_q.size() > 0 && n < budget) begin
            tick();
            n++;
            if (alternate) bus.instr_ready = ~bus.instr_ready;
        end
        bus.instr_ready = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d instructions still missing after %0d cycles", name, exp_q.size(), n);
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs [5];
        vecs[0] = '{32'h0000_0103, 32'h0000_0100, 4, 1'b0};
        vecs[1] = '{32'hFFFF_FFF9, 32'hFFFF_FFF8, 4, 1'b1};
        vecs[2] = '{32'h0000_2002, 32'h0000_2000, 3, 1'b0};
        vecs[3] = '{32'h8000_0000, 32'h8000_0000, 5, 1'b1};
        vecs[4] = '{32'h0000_0FFD, 32'h0000_0FFC, 2, 1'b0};

        // Reset state and zero-wait streaming.
        do_reset();
        check("reset_req", 32'(bus.imem_req), 32'd1);
        check("reset_addr", bus.imem_addr, 32'h0000_0000);
        check("reset_valid", 32'(bus.instr_valid), 32'd0);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(i) * 32'd4);
        drain(40, 1'b0, "stream");

        // Decode stall: two words buffered, requests stop, then pop in order.
        do_reset();
        repeat (4) tick();
        check("stall_req", 32'(bus.imem_req), 32'd0);
        check("stall_valid", 32'(bus.instr_valid), 32'd1);
        check("stall_head", bus.instr_pc, 32'h0000_0000);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0004);
        drain(10, 1'b0, "stall_release");

        // Redirect with two requests in flight: both stale responses dropped.
        do_reset();
        hold = 1'b1;
        tick();
        tick();
        check("two_out_req", 32'(bus.imem_req), 32'd0);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        #1;
        check("redir_req", 32'(bus.imem_req), 32'd0);
        tick();
        redirect = 1'b0;
        hold     = 1'b0;
        #1;
        check("redir_addr", bus.imem_addr, 32'h0000_0100);
        exp_q.push_back(32'h0000_0100);
        exp_q.push_back(32'h0000_0104);
        drain(40, 1'b0, "redir_drop");

        // Redirect coincident with a response and a pop.
        do_reset();
        hold = 1'b1;
        tick();
        tick();
        hold = 1'b0;
        tick();
        tick();
        bus.instr_ready = 1'b1;
        redirect        = 1'b1;
        redirect_pc     = 32'h0000_0200;
        #1;
        check("coinc_valid_before", 32'(bus.instr_valid), 32'd1);
        check("coinc_rvalid", 32'(bus.imem_rvalid), 32'd1);
        tick();
        redirect        = 1'b0;
        bus.instr_ready = 1'b0;
        #1;
        check("coinc_valid_after", 32'(bus.instr_valid), 32'd0);
        check("coinc_addr", bus.imem_addr, 32'h0000_0200);
        exp_q.push_back(32'h0000_0200);
        exp_q.push_back(32'h0000_0204);
        drain(40, 1'b0, "coinc");

        // PC wrap from FFFF_FFFC to 0.
        do_reset();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        tick();
        redirect = 1'b0;
        #1;
        check("wrap_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
        check("wrap_req", 32'(bus.imem_req), 32'd1);
        tick();
        check("wrap_addr_zero", bus.imem_addr, 32'h0000_0000);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        drain(40, 1'b0, "wrap");

        // Reset mid-transaction: the late response must not land in the buffer.
        do_reset();
        hold = 1'b1;
        tick();
        rst = 1'b1;
        #1;
        check("midrst_req", 32'(bus.imem_req), 32'd0);
        @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.imem_gnt = 1'b0;
        hold         = 1'b0;
        tick();
        tick();
        tick();
        check("midrst_valid", 32'(bus.instr_valid), 32'd0);
        bus.imem_gnt = 1'b1;
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0004);
        drain(40, 1'b0, "midrst");

        // Table of redirect runs from a busy, prefetching state.
        for (int k = 0; k < 5; k++) begin
            redirect    = 1'b1;
            redirect_pc = vecs[k].start;
            tick();
            redirect = 1'b0;
            for (int i = 0; i < vecs[k].n; i++) exp_q.push_back(vecs[k].first + (32'd4 * 32'(i)));
            drain(80, vecs[k].alt, "table_run");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
